// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 deframer that assembles WIDTH/8 bytes, most-significant first, into one word.
// Inter-byte idle time is bounded; a stalled partial word is dropped with an err pulse.
module uart_receiver #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             err,
    output logic             busy
);
    localparam int N  = WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
    localparam int BW = $clog2(N + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TOUT = CW'(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [BW-1:0] NB   = BW'(N);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state, state_n;
    logic [1:0]       sync;
    logic             rxd;
    logic [CW-1:0]    cnt, cnt_n, idle, idle_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       sh, sh_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic [WIDTH-1:0] word_shift, dout_n;
    logic             valid_n, err_n, accept;

    assign rxd  = sync[1];
    assign busy = (state != IDLE) || (bcnt != '0);

    // Only the low WIDTH-8 bits of the partial word survive the next shift, so only they are stored.
    if (WIDTH == 8) begin : g_byte
        assign word_shift = sh;
    end else begin : g_word
        logic [WIDTH-9:0] word;
        always_ff @(posedge clk or posedge rst)
            if (rst) word <= '0;
            else if (accept) word <= word_shift[WIDTH-9:0];
        assign word_shift = {word, sh};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            idle     <= '0;
            idx      <= '0;
            sh       <= '0;
            bcnt     <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            sync     <= {sync[0], din};
            state    <= state_n;
            cnt      <= cnt_n;
            idle     <= idle_n;
            idx      <= idx_n;
            sh       <= sh_n;
            bcnt     <= bcnt_n;
            data_out <= dout_n;
            valid    <= valid_n;
            err      <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idle_n  = idle;
        idx_n   = idx;
        sh_n    = sh;
        bcnt_n  = bcnt;
        dout_n  = data_out;
        valid_n = 1'b0;
        err_n   = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd) begin
                    state_n = START;
                    idle_n  = '0;
                end else if (bcnt != '0) begin
                    idle_n = idle + 1'b1;
                    if (idle_n == TOUT) begin
                        idle_n = '0;
                        bcnt_n = '0;
                        err_n  = 1'b1;
                    end
                end
            end
            START: if (cnt == HALF) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rxd ? IDLE : DATA;
            end
            DATA: if (cnt == FULL) begin
                cnt_n   = '0;
                sh_n    = {rxd, sh[7:1]};
                idx_n   = idx + 1'b1;
                state_n = (idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt == FULL) begin
                cnt_n = '0;
                if (rxd) begin
                    accept  = 1'b1;
                    state_n = IDLE;
                    bcnt_n  = bcnt + 1'b1;
                    if (bcnt_n == NB) begin
                        bcnt_n  = '0;
                        dout_n  = word_shift;
                        valid_n = 1'b1;
                    end
                end else begin
                    state_n = WAIT_HIGH;
                    bcnt_n  = '0;
                    err_n   = 1'b1;
                end
            end
            WAIT_HIGH: begin
                cnt_n   = '0;
                state_n = rxd ? IDLE : WAIT_HIGH;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver (16-bit words, 16 clks/bit, 4-bit-time timeout).
module tb_uart_receiver;
    localparam int C = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b1;
    logic [15:0] data_out;
    logic        valid, err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_err_cyc = -100000;
    logic [16:0] exp_q[$];

    uart_receiver #(.WIDTH(16), .CLKS_PER_BIT(C), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst(rst), .din(din),
        .data_out(data_out), .valid(valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: every valid/err pulse is matched against the next scoreboard entry {is_err, word}.
    always @(negedge clk) begin
        if (!rst && (valid || err)) begin
            logic [16:0] got, e;
            got = {err, valid ? data_out : 16'h0};
            checks++;
            if (err) last_err_cyc = cyc;
            if (valid && err) begin
                failures++;
                $display("FAIL both_pulses got valid=1 err=1 expected only one");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h expected=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL scoreboard got=%h expected=%h", got, e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic sb);
        din = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (C) @(negedge clk);
        end
        din = sb;
        repeat (C) @(negedge clk);
        din = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w);
        exp_q.push_back({1'b0, w});
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    initial begin
        int t_end;
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single word, back-to-back bytes
        send_word(16'hA53C);
        repeat (2) @(negedge clk);
        check("single_data_out", 32'(data_out), 32'hA53C);
        check("single_busy_low", 32'(busy), 32'h0);

        // Framing error followed by a good word
        exp_q.push_back(17'h10000);
        send_byte(8'h12, 1'b0);
        repeat (2 * C) @(negedge clk);
        check("frame_err_busy_low", 32'(busy), 32'h0);
        send_word(16'hBEEF);
        repeat (2) @(negedge clk);
        check("frame_data_out", 32'(data_out), 32'hBEEF);

        // Short glitch while idle
        din = 1'b0;
        repeat (3) @(negedge clk);
        din = 1'b1;
        repeat (C) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 32'h0);
        check("glitch_data_held", 32'(data_out), 32'hBEEF);

        // Inter-byte timeout drops the lone 0x11
        exp_q.push_back(17'h10000);
        send_byte(8'h11, 1'b1);
        t_end = cyc;
        check("timeout_busy_partial", 32'(busy), 32'h1);
        repeat (5 * C) @(negedge clk);
        check("timeout_err_window", 32'((last_err_cyc - t_end) >= 45 && (last_err_cyc - t_end) <= 75), 32'h1);
        check("timeout_busy_low", 32'(busy), 32'h0);
        send_word(16'h2233);
        repeat (2) @(negedge clk);
        check("timeout_data_out", 32'(data_out), 32'h2233);

        // Asynchronous reset during the data bits of the second byte
        send_byte(8'h77, 1'b1);
        din = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            din = i[0];
            repeat (C) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data_out", 32'(data_out), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_valid", 32'(valid), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        din = 1'b1;
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        send_word(16'h0102);
        repeat (2) @(negedge clk);
        check("post_reset_data_out", 32'(data_out), 32'h0102);

        // Continuous zero-gap stream
        for (int i = 0; i < 100; i++) send_word(16'($urandom));
        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("final_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
